// File: rtl/hilo_pkg.sv
// Shared types and constants for the HI/LO controller and the mult/div unit it drives.
// The default latency here must match the mult/div unit's pipeline depth.
package hilo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LAUNCH  = 2'd1,
    ST_WAIT    = 2'd2,
    ST_CAPTURE = 2'd3
  } hilo_state_e;

  localparam logic OP_DIV  = 1'b0;
  localparam logic OP_MULT = 1'b1;

  localparam int HILO_LATENCY = 33;
  localparam int HILO_CNT_W   = 6;

endpackage

// File: rtl/hilo_latency_counter.sv
// Loadable down-counter that times the mult/div unit latency.
// Holds at zero once drained; zero flag is a decode of the count register.
module hilo_latency_counter #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/hilo_controller.sv
// Initiator for the multiply/divide unit: launches ops, times the fixed latency,
// captures HI/LO and services MTHI/MTLO while idle.
//
// state      | meaning
// ST_IDLE    | accepts req / mthi / mtlo; done or div0_exc may pulse here
// ST_LAUNCH  | md_start pulse, latency counter loaded with LATENCY-1
// ST_WAIT    | counting down; a div aborts here on md_div0
// ST_CAPTURE | md_hi/md_lo copied into the architectural HI/LO
module hilo_controller
  import hilo_pkg::*;
#(
  parameter int LATENCY = HILO_LATENCY,
  parameter int CNT_W   = HILO_CNT_W
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        op,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wdata,
  input  logic [31:0] md_hi,
  input  logic [31:0] md_lo,
  input  logic        md_div0,
  output logic        md_start,
  output logic        md_control,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        div0_exc
);

  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(LATENCY - 1);

  hilo_state_e state;
  logic        op_q;
  logic        cnt_zero;

  hilo_latency_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (state == ST_LAUNCH),
    .en       (state == ST_WAIT),
    .load_val (LOAD_VAL),
    .zero     (cnt_zero)
  );

  // op select is held from launch until the next accepted request
  assign md_control = op_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      hi       <= '0;
      lo       <= '0;
      op_q     <= OP_DIV;
      md_start <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div0_exc <= 1'b0;
    end else begin
      md_start <= 1'b0;
      done     <= 1'b0;
      div0_exc <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (mthi) hi <= wdata;
          if (mtlo) lo <= wdata;
          if (req) begin
            op_q     <= op;
            md_start <= 1'b1;
            busy     <= 1'b1;
            state    <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          // divide-by-zero abort wins even on the final counted cycle
          if ((op_q == OP_DIV) && md_div0) begin
            div0_exc <= 1'b1;
            busy     <= 1'b0;
            state    <= ST_IDLE;
          end else if (cnt_zero) begin
            state <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          hi    <= md_hi;
          lo    <= md_lo;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_controller.sv
// Randomized bench for hilo_controller against a timeline model: each accepted op
// is described by its launch cycle, abort cycle and result, and outputs are derived from those.
module tb_hilo_controller;
  import hilo_pkg::*;

  localparam int LATENCY = 33;

  logic        clk;
  logic        reset;
  logic        req;
  logic        op;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wdata;
  logic [31:0] md_hi;
  logic [31:0] md_lo;
  logic        md_div0;
  logic        md_start;
  logic        md_control;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        div0_exc;

  hilo_controller #(
    .LATENCY (LATENCY),
    .CNT_W   (6)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .op         (op),
    .mthi       (mthi),
    .mtlo       (mtlo),
    .wdata      (wdata),
    .md_hi      (md_hi),
    .md_lo      (md_lo),
    .md_div0    (md_div0),
    .md_start   (md_start),
    .md_control (md_control),
    .hi         (hi),
    .lo         (lo),
    .busy       (busy),
    .done       (done),
    .div0_exc   (div0_exc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // timeline model
  int          c;
  int          launch;
  int          abort;
  int          pulse;
  int          done_at;
  int          exc_at;
  logic        mop;
  logic [31:0] hi_m;
  logic [31:0] lo_m;
  logic [31:0] res_hi;
  logic [31:0] res_lo;
  logic [31:0] nres_hi;
  logic [31:0] nres_lo;
  bit          div0_hold;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %h expected %h", tag, c, got, exp);
    end
  endtask

  task automatic model_reset();
    launch  = -1;
    abort   = -1;
    pulse   = -1;
    done_at = -1;
    exc_at  = -1;
    mop     = OP_DIV;
    hi_m    = '0;
    lo_m    = '0;
  endtask

  // one cycle: check outputs of cycle c, drive inputs for cycle c, advance the model to c+1
  task automatic step(input logic r, input logic o, input logic wh, input logic wl,
                      input logic [31:0] wd, input logic rs, input int pulse_rel);
    int end_c;
    bit bz;
    end_c = (abort >= 0) ? abort : launch + LATENCY + 1;
    bz    = (launch >= 0) && (c >= launch) && (c <= end_c);

    check_eq("busy",       32'(busy),       32'(bz));
    check_eq("md_start",   32'(md_start),   32'(c == launch));
    check_eq("done",       32'(done),       32'(c == done_at));
    check_eq("div0_exc",   32'(div0_exc),   32'(c == exc_at));
    check_eq("md_control", 32'(md_control), 32'(mop));
    check_eq("hi",         hi,              hi_m);
    check_eq("lo",         lo,              lo_m);

    reset = rs;
    req   = r;
    op    = o;
    mthi  = wh;
    mtlo  = wl;
    wdata = wd;
    if (bz && (mop == OP_DIV)) md_div0 = (c == pulse);
    else                       md_div0 = div0_hold | 1'($urandom_range(0, 1));
    if (bz && (c >= launch + LATENCY)) begin
      md_hi = res_hi;
      md_lo = res_lo;
    end else begin
      md_hi = $urandom;
      md_lo = $urandom;
    end

    if (rs) begin
      model_reset();
    end else if (bz) begin
      if ((abort < 0) && (c == launch + LATENCY + 1)) begin
        hi_m = res_hi;
        lo_m = res_lo;
      end
    end else begin
      if (wh) hi_m = wd;
      if (wl) lo_m = wd;
      if (r) begin
        launch  = c + 1;
        mop     = o;
        res_hi  = nres_hi;
        res_lo  = nres_lo;
        pulse   = (pulse_rel > 0) ? c + pulse_rel : -1;
        abort   = ((o == OP_DIV) && (pulse >= launch + 1) && (pulse <= launch + LATENCY)) ? pulse : -1;
        done_at = (abort < 0) ? launch + LATENCY + 2 : -1;
        exc_at  = (abort < 0) ? -1 : abort + 1;
      end
    end

    @(negedge clk);
    c++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, -1);
  endtask

  initial begin
    reset     = 1'b1;
    req       = 1'b0;
    op        = 1'b0;
    mthi      = 1'b0;
    mtlo      = 1'b0;
    wdata     = '0;
    md_hi     = '0;
    md_lo     = '0;
    md_div0   = 1'b0;
    div0_hold = 1'b0;
    res_hi    = '0;
    res_lo    = '0;
    nres_hi   = 32'h1;
    nres_lo   = 32'h2;
    c         = 0;
    model_reset();
    @(negedge clk);
    @(negedge clk);

    // MTHI then MTLO
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF, 1'b0, -1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h12345678, 1'b0, -1);
    idle(2);

    // mult, result 1/2
    step(1'b1, OP_MULT, 1'b0, 1'b0, 32'h0, 1'b0, -1);
    idle(40);

    // div aborted by divide-by-zero at req+5
    nres_hi = 32'hAAAA_0001;
    nres_lo = 32'hBBBB_0002;
    step(1'b1, OP_DIV, 1'b0, 1'b0, 32'h0, 1'b0, 5);
    idle(40);

    // mult with md_div0 held high
    div0_hold = 1'b1;
    nres_hi   = 32'h0000_0033;
    nres_lo   = 32'h0000_0044;
    step(1'b1, OP_MULT, 1'b0, 1'b0, 32'h0, 1'b0, -1);
    idle(40);
    div0_hold = 1'b0;

    // req and mthi every cycle: ignored while busy, re-launch in done cycle
    for (int i = 0; i < 80; i++) begin
      nres_hi = $urandom;
      nres_lo = $urandom;
      step(1'b1, OP_MULT, 1'b1, 1'b0, $urandom, 1'b0, -1);
    end
    idle(40);

    // div aborts at the last WAIT cycle and in LAUNCH/CAPTURE (ignored there)
    step(1'b1, OP_DIV, 1'b0, 1'b0, 32'h0, 1'b0, LATENCY + 1);
    idle(40);
    step(1'b1, OP_DIV, 1'b0, 1'b0, 32'h0, 1'b0, 1);
    idle(40);
    step(1'b1, OP_DIV, 1'b0, 1'b0, 32'h0, 1'b0, LATENCY + 2);
    idle(40);

    // reset at c10 of a mult
    step(1'b1, OP_MULT, 1'b0, 1'b0, 32'h0, 1'b0, -1);
    idle(9);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, -1);
    idle(40);

    for (int i = 0; i < 3000; i++) begin
      nres_hi = $urandom;
      nres_lo = $urandom;
      step(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
           $urandom, 1'($urandom_range(0, 299) == 0),
           ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, LATENCY + 2)) : -1);
    end
    idle(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
